// File: rtl/seq_mult_param.sv
// -----------------------------------------------------------------------------
// seq_mult_param
//
// Sequential shift-and-add multiplier with its control FSM.
// Both operands are reduced to magnitudes when the operation starts. The
// magnitudes are then multiplied with one add/shift step per clock. The sign
// is applied once, on the edge that leaves CALC. With EARLY_TERM=1 the loop
// stops as soon as the remaining multiplier bits are all zero.
//
// Parameters:
//   WIDTH       operand width (>= 2); the product is 2*WIDTH bits
//   EARLY_TERM  1 = stop when the remaining multiplier bits are zero
//   CW          width of iter_count
//
// Ports:
//   Clock        in   rising-edge clock
//   Reset_n      in   synchronous active-low reset
//   valid_data   in   start request, sampled in IDLE only
//   signed_mode  in   1 = two's-complement operands, sampled with a/b
//   a            in   multiplicand [WIDTH]
//   b            in   multiplier   [WIDTH]
//   ack          in   result consumed, sampled in DONE only
//   busy         out  registered, high while in CALC
//   done         out  registered, high while in DONE
//   product      out  registered result [2*WIDTH]
//   iter_count   out  CALC cycles used by the last operation [CW]
// -----------------------------------------------------------------------------
module seq_mult_param #(
    parameter int WIDTH      = 32,
    parameter bit EARLY_TERM = 1'b1,
    parameter int CW         = $clog2(WIDTH + 1)
) (
    input  logic                 Clock,
    input  logic                 Reset_n,
    input  logic                 valid_data,
    input  logic                 signed_mode,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    input  logic                 ack,
    output logic                 busy,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product,
    output logic [CW-1:0]        iter_count
);

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        CALC = 2'b01,
        DONE = 2'b10
    } state_t;

    localparam logic [CW-1:0]      CNT_ONE  = {{(CW-1){1'b0}}, 1'b1};
    localparam logic [CW-1:0]      CNT_LAST = CW'(WIDTH);
    localparam logic [2*WIDTH-1:0] P_ONE    = {{(2*WIDTH-1){1'b0}}, 1'b1};

    // Magnitude of an operand. For the most negative value the result
    // 2^(WIDTH-1) still fits unsigned in WIDTH bits, so no widening is needed.
    function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x,
                                                   input logic             is_signed);
        logic [WIDTH-1:0] m;
        if (is_signed && x[WIDTH-1]) begin
            m = (~x) + {{(WIDTH-1){1'b0}}, 1'b1};
        end else begin
            m = x;
        end
        return m;
    endfunction

    state_t               state_r;
    logic [2*WIDTH-1:0]   a_r;      // shifted multiplicand magnitude
    logic [WIDTH-1:0]     b_r;      // remaining multiplier magnitude bits
    logic [2*WIDTH-1:0]   acc_r;    // partial product of magnitudes
    logic [CW-1:0]        cnt_r;    // iterations done so far
    logic                 neg_r;    // result must be negated

    logic [2*WIDTH-1:0]   acc_next_s;
    logic [2*WIDTH-1:0]   a_next_s;
    logic [WIDTH-1:0]     b_next_s;
    logic [CW-1:0]        cnt_next_s;
    logic                 exit_s;
    logic [2*WIDTH-1:0]   result_s;

    // One shift-and-add step, and the exit test on the post-step values.
    always_comb begin
        acc_next_s = acc_r;
        a_next_s   = {a_r[2*WIDTH-2:0], 1'b0};
        b_next_s   = {1'b0, b_r[WIDTH-1:1]};
        cnt_next_s = cnt_r + CNT_ONE;
        exit_s     = 1'b0;
        result_s   = acc_r;

        if (b_r[0]) begin
            acc_next_s = acc_r + a_r;
        end else begin
            acc_next_s = acc_r;
        end

        // Early exit only looks at the multiplier bits left after this step.
        if (cnt_next_s == CNT_LAST) begin
            exit_s = 1'b1;
        end else if (EARLY_TERM && (b_next_s == {WIDTH{1'b0}})) begin
            exit_s = 1'b1;
        end else begin
            exit_s = 1'b0;
        end

        // Negating a zero accumulator wraps back to zero, so -0 never appears.
        if (neg_r) begin
            result_s = (~acc_next_s) + P_ONE;
        end else begin
            result_s = acc_next_s;
        end
    end

    // Control FSM, datapath registers and registered status outputs.
    always_ff @(posedge Clock) begin
        if (!Reset_n) begin
            state_r    <= IDLE;
            a_r        <= {(2*WIDTH){1'b0}};
            b_r        <= {WIDTH{1'b0}};
            acc_r      <= {(2*WIDTH){1'b0}};
            cnt_r      <= {CW{1'b0}};
            neg_r      <= 1'b0;
            busy       <= 1'b0;
            done       <= 1'b0;
            product    <= {(2*WIDTH){1'b0}};
            iter_count <= {CW{1'b0}};
        end else begin
            case (state_r)
                IDLE: begin
                    if (valid_data) begin
                        a_r     <= {{WIDTH{1'b0}}, magnitude(a, signed_mode)};
                        b_r     <= magnitude(b, signed_mode);
                        acc_r   <= {(2*WIDTH){1'b0}};
                        cnt_r   <= {CW{1'b0}};
                        neg_r   <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
                        state_r <= CALC;
                        busy    <= 1'b1;
                        done    <= 1'b0;
                    end
                end
                CALC: begin
                    a_r   <= a_next_s;
                    b_r   <= b_next_s;
                    acc_r <= acc_next_s;
                    cnt_r <= cnt_next_s;
                    if (exit_s) begin
                        product    <= result_s;
                        iter_count <= cnt_next_s;
                        state_r    <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                    end
                end
                DONE: begin
                    // valid_data is ignored here, so a start needs a cycle in IDLE.
                    if (ack) begin
                        state_r <= IDLE;
                        done    <= 1'b0;
                    end
                end
                default: begin
                    // The unused encoding recovers to IDLE.
                    state_r <= IDLE;
                    busy    <= 1'b0;
                    done    <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_seq_mult_param.sv
// -----------------------------------------------------------------------------
// tb_seq_mult_param
//
// Directed bench for seq_mult_param. Two 8-bit instances share one set of
// inputs: one always runs the full loop and one terminates early. Two 32-bit
// instances are configured the same way and are driven by a signed sweep
// against a 64-bit reference product.
// -----------------------------------------------------------------------------
module tb_seq_mult_param;

    logic clk = 1'b0;
    logic rst_n;

    // 8-bit group
    logic        v8, m8, ack8;
    logic [7:0]  a8, b8;
    logic        busy_f, done_f, busy_e, done_e;
    logic [15:0] prod_f, prod_e;
    logic [3:0]  it_f, it_e;

    // 32-bit group
    logic        v32, m32, ack32;
    logic [31:0] a32, b32;
    logic        busy32_f, done32_f, busy32_e, done32_e;
    logic [63:0] prod32_f, prod32_e;
    logic [5:0]  it32_f, it32_e;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_mult_param #(.WIDTH(8), .EARLY_TERM(1'b0)) u_f8 (
        .Clock(clk), .Reset_n(rst_n), .valid_data(v8), .signed_mode(m8),
        .a(a8), .b(b8), .ack(ack8), .busy(busy_f), .done(done_f),
        .product(prod_f), .iter_count(it_f));

    seq_mult_param #(.WIDTH(8), .EARLY_TERM(1'b1)) u_e8 (
        .Clock(clk), .Reset_n(rst_n), .valid_data(v8), .signed_mode(m8),
        .a(a8), .b(b8), .ack(ack8), .busy(busy_e), .done(done_e),
        .product(prod_e), .iter_count(it_e));

    seq_mult_param #(.WIDTH(32), .EARLY_TERM(1'b0)) u_f32 (
        .Clock(clk), .Reset_n(rst_n), .valid_data(v32), .signed_mode(m32),
        .a(a32), .b(b32), .ack(ack32), .busy(busy32_f), .done(done32_f),
        .product(prod32_f), .iter_count(it32_f));

    seq_mult_param #(.WIDTH(32), .EARLY_TERM(1'b1)) u_e32 (
        .Clock(clk), .Reset_n(rst_n), .valid_data(v32), .signed_mode(m32),
        .a(a32), .b(b32), .ack(ack32), .busy(busy32_e), .done(done32_e),
        .product(prod32_e), .iter_count(it32_e));

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_value(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
        end
    endtask

    // One 8-bit operation on both instances. With noise set, the operands,
    // mode and valid_data wiggle during CALC/DONE, and ack pulses during CALC.
    task automatic op8(input string tag, input logic [7:0] av, input logic [7:0] bv,
                       input logic mv, input logic [15:0] exp_p, input int exp_ke,
                       input bit noise, input int hold);
        int lat_f;
        int lat_e;
        lat_f = 0;
        lat_e = 0;
        a8 = av; b8 = bv; m8 = mv; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        check_value({tag, "/busy_f"}, 64'(busy_f), 64'd1);
        check_value({tag, "/busy_e"}, 64'(busy_e), 64'd1);
        for (int c = 1; c <= 40 && (lat_f == 0 || lat_e == 0); c++) begin
            if (noise) begin
                v8   = c[0];
                a8   = ~av;
                b8   = bv ^ 8'h5A;
                m8   = ~mv;
                ack8 = c[0] & busy_f & busy_e;
            end
            tick();
            if (done_f && lat_f == 0) lat_f = c;
            if (done_e && lat_e == 0) lat_e = c;
        end
        v8 = 1'b0;
        ack8 = 1'b0;
        check_value({tag, "/lat_f"},  64'(lat_f),  64'd8);
        check_value({tag, "/iter_f"}, 64'(it_f),   64'd8);
        check_value({tag, "/prod_f"}, 64'(prod_f), 64'(exp_p));
        check_value({tag, "/lat_e"},  64'(lat_e),  64'(exp_ke));
        check_value({tag, "/iter_e"}, 64'(it_e),   64'(exp_ke));
        check_value({tag, "/prod_e"}, 64'(prod_e), 64'(exp_p));
        if (hold > 0) begin
            repeat (hold) tick();
            check_value({tag, "/hold_done"}, 64'(done_f), 64'd1);
            check_value({tag, "/hold_prod"}, 64'(prod_f), 64'(exp_p));
        end
        ack8 = 1'b1;
        tick();
        ack8 = 1'b0;
        check_value({tag, "/idle_done_f"}, 64'(done_f), 64'd0);
        check_value({tag, "/idle_done_e"}, 64'(done_e), 64'd0);
        check_value({tag, "/idle_busy_f"}, 64'(busy_f), 64'd0);
        check_value({tag, "/idle_busy_e"}, 64'(busy_e), 64'd0);
    endtask

    // Start one operation while ack is held high and count cycles with done set.
    task automatic op8_ack_held(input string tag, input logic [7:0] av, input logic [7:0] bv,
                                input logic [15:0] exp_p, input int exp_ke);
        int nd_f;
        int nd_e;
        nd_f = 0;
        nd_e = 0;
        a8 = av; b8 = bv; m8 = 1'b0; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        repeat (12) begin
            tick();
            if (done_f) nd_f++;
            if (done_e) nd_e++;
        end
        check_value({tag, "/ndone_f"}, 64'(nd_f),   64'd1);
        check_value({tag, "/ndone_e"}, 64'(nd_e),   64'd1);
        check_value({tag, "/prod_f"},  64'(prod_f), 64'(exp_p));
        check_value({tag, "/prod_e"},  64'(prod_e), 64'(exp_p));
        check_value({tag, "/iter_e"},  64'(it_e),   64'(exp_ke));
    endtask

    initial begin
        logic [31:0]        mb;
        logic signed [63:0] ref_p;
        int                 k;
        int                 lat_f;
        int                 lat_e;

        rst_n = 1'b0;
        v8 = 1'b0; m8 = 1'b0; ack8 = 1'b0; a8 = 8'd0; b8 = 8'd0;
        v32 = 1'b0; m32 = 1'b0; ack32 = 1'b0; a32 = 32'd0; b32 = 32'd0;
        tick();
        tick();
        rst_n = 1'b1;
        check_value("rst/busy", 64'(busy_f), 64'd0);
        check_value("rst/done", 64'(done_f), 64'd0);
        check_value("rst/prod", 64'(prod_f), 64'd0);
        check_value("rst/iter", 64'(it_f),   64'd0);

        // Directed 8-bit vectors
        op8("u200x150", 8'd200, 8'd150, 1'b0, 16'h7530, 8, 1'b1, 20);
        op8("s-128x-128", 8'h80, 8'h80, 1'b1, 16'h4000, 8, 1'b0, 0);
        op8("s-3x5",      8'hFD, 8'h05, 1'b1, 16'hFFF1, 3, 1'b0, 0);
        op8("u253x5",     8'hFD, 8'h05, 1'b0, 16'h04F1, 3, 1'b0, 0);
        op8("u7x3",       8'd7,  8'h03, 1'b0, 16'd21,   2, 1'b0, 0);
        op8("u99x0",      8'd99, 8'h00, 1'b0, 16'd0,    1, 1'b0, 0);
        op8("s-5x0",      8'hFB, 8'h00, 1'b1, 16'd0,    1, 1'b0, 0);
        op8("s127x-1",    8'h7F, 8'hFF, 1'b1, 16'hFF81, 1, 1'b0, 0);
        op8("u255x255",   8'hFF, 8'hFF, 1'b0, 16'hFE01, 8, 1'b0, 0);
        op8("s-128x1",    8'h80, 8'h01, 1'b1, 16'hFF80, 1, 1'b0, 0);
        op8("s-1x-1",     8'hFF, 8'hFF, 1'b1, 16'h0001, 1, 1'b0, 0);
        op8("s100x-2",    8'h64, 8'hFE, 1'b1, 16'hFF38, 2, 1'b0, 0);

        // ack held high across two back-to-back operations
        ack8 = 1'b1;
        op8_ack_held("ackhold1", 8'd5, 8'd6, 16'd30, 3);
        op8_ack_held("ackhold2", 8'd9, 8'd3, 16'd27, 2);
        ack8 = 1'b0;
        tick();

        // Reset during the third CALC cycle
        a8 = 8'd200; b8 = 8'd150; m8 = 1'b0; v8 = 1'b1;
        tick();
        v8 = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        check_value("midrst/busy_f", 64'(busy_f), 64'd0);
        check_value("midrst/done_f", 64'(done_f), 64'd0);
        check_value("midrst/prod_f", 64'(prod_f), 64'd0);
        check_value("midrst/iter_f", 64'(it_f),   64'd0);
        check_value("midrst/busy_e", 64'(busy_e), 64'd0);
        check_value("midrst/prod_e", 64'(prod_e), 64'd0);
        check_value("midrst/iter_e", 64'(it_e),   64'd0);
        op8("rst_12x12", 8'd12, 8'd12, 1'b0, 16'd144, 4, 1'b0, 0);

        // 32-bit signed sweep against a 64-bit reference product
        for (int i = 0; i < 1000; i++) begin
            a32 = $urandom;
            b32 = $urandom;
            if (i % 4 == 1) b32 = 32'($urandom_range(0, 255));
            if (i % 4 == 2) b32 = 32'd0 - 32'($urandom_range(1, 255));
            if (i == 0) begin a32 = 32'h8000_0000; b32 = 32'h8000_0000; end
            if (i == 1) begin a32 = 32'h8000_0000; b32 = 32'h7FFF_FFFF; end
            if (i == 2) begin a32 = 32'hFFFF_FFFF; b32 = 32'h0000_0000; end
            ref_p = $signed({{32{a32[31]}}, a32}) * $signed({{32{b32[31]}}, b32});
            mb = b32[31] ? (~b32 + 32'd1) : b32;
            k = 1;
            for (int j = 0; j < 32; j++) begin
                if (mb[j]) k = j + 1;
            end
            m32 = 1'b1;
            v32 = 1'b1;
            tick();
            v32 = 1'b0;
            lat_f = 0;
            lat_e = 0;
            for (int c = 1; c <= 40 && (lat_f == 0 || lat_e == 0); c++) begin
                tick();
                if (done32_f && lat_f == 0) lat_f = c;
                if (done32_e && lat_e == 0) lat_e = c;
            end
            check_value("w32/prod_f", prod32_f,       ref_p);
            check_value("w32/iter_f", 64'(it32_f),    64'd32);
            check_value("w32/lat_f",  64'(lat_f),     64'd32);
            check_value("w32/prod_e", prod32_e,       ref_p);
            check_value("w32/iter_e", 64'(it32_e),    64'(k));
            check_value("w32/lat_e",  64'(lat_e),     64'(k));
            ack32 = 1'b1;
            tick();
            ack32 = 1'b0;
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/seq_mult_param.md
Name: seq_mult_param

Overview:
- Parametrised sequential shift-and-add multiplier with integrated datapath and control FSM.
- Successor to the fixed 32-bit multiplier controller.
- Adds generic operand width, a per-operation signed/unsigned mode, optional early termination on an exhausted multiplier, and an iteration-count status output.
- Sits between an operand producer (valid_data handshake) and a result consumer (ack handshake).

Parameters:
- WIDTH, 32: operand width in bits; product is 2*WIDTH. Legal range is 2 or more.
- EARLY_TERM, 1: 1 = leave CALC as soon as the remaining multiplier bits are all zero; 0 = always run WIDTH iterations.
- CW, $clog2(WIDTH+1): width of iter_count.

Ports:
- Clock  input  1  single clock; all state updates on the rising edge.
- Reset_n  input  1  reset, synchronous and active-low.
- valid_data  input  1  operands valid; sampled only in IDLE.
- signed_mode  input  1  1 = two's-complement operands; 0 = unsigned. Sampled with operands.
- a  input  WIDTH  multiplicand.
- b  input  WIDTH  multiplier.
- ack  input  1  consumer has read product; sampled only in DONE.
- busy  output  1  high in CALC.
- done  output  1  high in DONE.
- product  output  2*WIDTH  result register.
- iter_count  output  CW  number of CALC cycles used by the last operation.

Behaviour:
- Reset: Reset_n low at a rising edge forces IDLE on the following cycle, regardless of state, including mid-CALC.
  - busy=0, done=0, product=0, iter_count=0; all internal registers cleared.
  - Any in-flight operation is discarded.
- States: IDLE, CALC, DONE (2-bit encoding). Outputs are Moore and registered: busy=(state==CALC), done=(state==DONE).
- IDLE:
  - valid_data=1 at an edge loads the operands:
    - a_reg = |a| zero-extended to 2*WIDTH.
    - b_reg = |b| (WIDTH bits).
    - acc = 0, cnt = 0.
    - neg = signed_mode & (a[MSB] ^ b[MSB]).
  - Then go to CALC. With signed_mode=0, |x| = x and neg=0.
  - |-2^(WIDTH-1)| = 2^(WIDTH-1) fits unsigned in WIDTH bits; no overflow.
  - product and iter_count keep their previous values until the operation completes.
- CALC, one iteration per edge:
  - If b_reg[0], then acc += a_reg (2*WIDTH-bit add, no overflow possible).
  - a_reg <<= 1; b_reg >>= 1; cnt += 1.
  - Exit condition, evaluated on the post-iteration values: (cnt == WIDTH) or (EARLY_TERM and the shifted b_reg == 0).
  - On the exit edge:
    - product <= neg ? -(acc_next) : acc_next (two's complement, 2*WIDTH bits).
    - iter_count <= cnt_next.
    - Go to DONE.
- DONE:
  - product is held stable and done=1 until ack=1 is sampled; then go to IDLE on the next edge.
  - ack held high continuously produces exactly one DONE to IDLE transition per operation.
- Latency:
  - valid_data sampled at edge N gives busy=1 after edge N.
  - done=1 after edge N+k, where k = iter_count.
  - EARLY_TERM=0: k = WIDTH.
  - EARLY_TERM=1: k = max(1, index of highest set bit of |b| + 1). b=0 gives k=1 and product 0.
- Ignored inputs:
  - valid_data outside IDLE is ignored; no queueing, and operand/mode changes during CALC/DONE have no effect.
  - ack outside DONE is ignored.
  - A valid_data and ack pulse in the same cycle in DONE: only ack acts. The next operation needs valid_data in IDLE, so there is a minimum 1-cycle IDLE gap between operations.
- A zero product is positive zero: neg with acc=0 yields 0.

Test Plan:
- WIDTH=8, EARLY_TERM=0, unsigned:
  - Stimulus: a=200, b=150, valid_data pulse.
  - Required: busy for 8 cycles; done=1 with product=16'h7530 (30000) and iter_count=8; held until ack; IDLE one cycle after ack.
- WIDTH=8, signed_mode=1, a=-128, b=-128:
  - Required: product=16'h4000 (16384).
  - Then a=-3, b=5 must give product=16'hFFF1 (-15).
- WIDTH=8, EARLY_TERM=1:
  - b=8'h03, a=7: product=21, iter_count=2.
  - b=0, a=99: product=0, iter_count=1, done after 1 CALC cycle.
- Reset mid-CALC:
  - Stimulus: start 200*150, drive Reset_n low for one edge at cycle 3 of CALC.
  - Required: next cycle is IDLE with busy=0, done=0, product=0, iter_count=0.
  - A new operation 12*12 then yields 144.
- Handshake robustness:
  - valid_data toggling with different operands during CALC/DONE does not change the result.
  - ack pulses during CALC are ignored; done stays asserted for 20 cycles until ack.
  - ack held high across two back-to-back operations gives exactly one completion each.
- WIDTH=32 (default) signed random sweep of 1000 pairs:
  - Required: product matches a 64-bit reference model.
  - iter_count = 32 for EARLY_TERM=0, otherwise per the latency rule.
